// File: rtl/iir_cap_pkg.sv
// iir_cap_pkg
// Shared definitions for the IIR output capture block:
//   - cap_state_e : capture FSM state encoding (IDLE / CAPTURE / DONE)
//   - DATA_W_DEF  : default sample width (Q1.15)
//   - Q15_MAX / Q15_MIN : Q1.15 extreme values
package iir_cap_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/iir_out_capture_if.sv
// iir_out_capture_if
// Bundles the sample stream, the readback port and the status outputs of the
// capture block.
//   master : the filter/host side (drives start, din, din_valid, rd_en, rd_addr)
//   slave  : the capture block (drives rd_data, rd_valid, wr_count, busy, done,
//            overrun, stable, peak_abs, checksum)
interface iir_out_capture_if
    import iir_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 11
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   wr_count;
    logic              busy;
    logic              done;
    logic              overrun;
    logic              stable;
    logic [DATA_W-1:0] peak_abs;
    logic [31:0]       checksum;

    modport master (
        output start, din, din_valid, rd_en, rd_addr,
        input  rd_data, rd_valid, wr_count, busy, done, overrun, stable,
               peak_abs, checksum
    );

    modport slave (
        input  start, din, din_valid, rd_en, rd_addr,
        output rd_data, rd_valid, wr_count, busy, done, overrun, stable,
               peak_abs, checksum
    );

endinterface

// File: rtl/iir_cap_ram.sv
// iir_cap_ram
// DEPTH x DATA_W simple dual-port RAM: one synchronous write port and one
// registered read port, written so that synthesis maps it onto block RAM.
// Ports:
//   clk, rst          clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr     read request; rd_data valid the next cycle, held otherwise
module iir_cap_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The output register resets so rd_data reads 0 out of reset; block RAM
    // output registers support a synchronous reset natively.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/iir_out_capture.sv
// iir_out_capture
// Downstream sink for the 6-stage SOS IIR: captures DEPTH filtered samples into
// a buffer for readback, tracking peak |din| and a settling (stable) flag.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high (wins over start)
//   bus   iir_out_capture_if.slave: start/din/din_valid in, rd_en/rd_addr in,
//         rd_data/rd_valid, wr_count, busy, done, overrun, stable, peak_abs,
//         checksum out
// Configuration:
//   IIR_CAP_CHECKSUM_EN  when defined, checksum is the running mod-2^32 sum of
//                        sign-extended captured samples; otherwise tied to 0.
module iir_out_capture
    import iir_cap_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = 2048,
    parameter int ADDR_W     = 11,
    parameter int TOL        = 16,
    parameter int STABLE_CNT = 64
) (
    input  logic clk,
    input  logic rst,
    iir_out_capture_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   WR_INC   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W:0]   TOL_C    = (DATA_W+1)'(TOL);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0]  CNT_INC  = CNT_W'(1);

    cap_state_e state_q, state_d;

    logic [ADDR_W:0]   wr_count_q;
    logic [DATA_W-1:0] peak_q;
    logic [DATA_W-1:0] prev_q;
    logic              have_prev_q;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic              stable_q;
    logic              overrun_q;
    logic              rd_valid_q;
    logic              rd_oor_q;
    logic [DATA_W-1:0] ram_rd_data;

    logic                     capture_en;
    logic                     last_write;
    logic                     rd_fire;
    logic signed [DATA_W:0]   din_ext;
    logic signed [DATA_W:0]   prev_ext;
    logic [DATA_W:0]          din_mag;
    logic [DATA_W-1:0]        din_abs;
    logic signed [DATA_W:0]   diff;
    logic [DATA_W:0]          diff_mag;
    logic                     within_tol;

    // A start in the same cycle as a valid sample re-arms the run and drops
    // that sample, so start masks the capture strobe.
    assign capture_en = (state_q == ST_CAPTURE) && bus.din_valid && !bus.start;
    assign last_write = capture_en && (wr_count_q == LAST_IDX);
    assign rd_fire    = bus.rd_en && (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ST_CAPTURE;
        end else if (last_write) begin
            state_d = ST_DONE;
        end
    end

    // Magnitude at DATA_W+1 bits so the most negative code does not wrap;
    // it is then saturated to the largest positive code.
    assign din_ext  = {bus.din[DATA_W-1], bus.din};
    assign prev_ext = {prev_q[DATA_W-1], prev_q};
    assign din_mag  = din_ext[DATA_W] ? -din_ext : din_ext;
    assign din_abs  = (din_mag[DATA_W] || din_mag[DATA_W-1]) ? MAG_MAX
                                                             : din_mag[DATA_W-1:0];

    // Step between consecutive samples; DATA_W+1 signed bits hold any
    // difference and its magnitude fits unsigned in the same width.
    assign diff       = din_ext - prev_ext;
    assign diff_mag   = diff[DATA_W] ? -diff : diff;
    assign within_tol = (diff_mag <= TOL_C);

    always_comb begin
        settle_cnt_d = settle_cnt_q;
        if (have_prev_q) begin
            if (within_tol) begin
                if (settle_cnt_q != CNT_MAX) begin
                    settle_cnt_d = settle_cnt_q + CNT_INC;
                end
            end else begin
                settle_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            wr_count_q   <= '0;
            peak_q       <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            settle_cnt_q <= '0;
            stable_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (capture_en) begin
                wr_count_q   <= wr_count_q + WR_INC;
                prev_q       <= bus.din;
                have_prev_q  <= 1'b1;
                settle_cnt_q <= settle_cnt_d;
                stable_q     <= (settle_cnt_d == CNT_MAX);
                if (din_abs > peak_q) begin
                    peak_q <= din_abs;
                end
            end
            if ((state_q == ST_DONE) && bus.din_valid) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Out-of-range read addresses return zero; the flag is captured alongside
    // the RAM read so rd_data stays held between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_oor_q <= ({1'b0, bus.rd_addr} >= DEPTH_C);
            end
        end
    end

    iir_cap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture_en),
        .wr_addr (wr_count_q[ADDR_W-1:0]),
        .wr_data (bus.din),
        .rd_en   (rd_fire),
        .rd_addr (bus.rd_addr),
        .rd_data (ram_rd_data)
    );

`ifdef IIR_CAP_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            checksum_q <= '0;
        end else if (capture_en) begin
            checksum_q <= checksum_q + {{(32-DATA_W){bus.din[DATA_W-1]}}, bus.din};
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = 32'h0;
`endif

    assign bus.rd_data  = rd_oor_q ? '0 : ram_rd_data;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_count = wr_count_q;
    assign bus.busy     = (state_q == ST_CAPTURE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.overrun  = overrun_q;
    assign bus.stable   = stable_q;
    assign bus.peak_abs = peak_q;

endmodule

// File: tb/tb_iir_out_capture.sv
// tb_iir_out_capture
// Directed testbench for iir_out_capture: reset behaviour, full capture runs,
// sparse valids, settling flag, peak saturation, overrun, restart and readback.
// Checksum expectations follow IIR_CAP_CHECKSUM_EN.
module tb_iir_out_capture;
    import iir_cap_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iir_out_capture_if #(.DATA_W(16), .ADDR_W(11)) bus ();

    iir_out_capture #(
        .DATA_W     (16),
        .DEPTH      (2048),
        .ADDR_W     (11),
        .TOL        (16),
        .STABLE_CNT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance one cycle and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One cycle of stream input; start and din_valid are pulses
    task automatic applyStimulus(input logic s, input logic v, input logic [15:0] d);
        bus.start     = s;
        bus.din_valid = v;
        bus.din       = d;
        tick();
        bus.start     = 1'b0;
        bus.din_valid = 1'b0;
    endtask

    task automatic readBack(input logic [10:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_sum;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_busy",     32'(bus.busy),     32'h0);
        checkOutput("rst_done",     32'(bus.done),     32'h0);
        checkOutput("rst_wr_count", 32'(bus.wr_count), 32'h0);
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        checkOutput("rst_rd_data",  32'(bus.rd_data),  32'h0);
        checkOutput("rst_overrun",  32'(bus.overrun),  32'h0);
        checkOutput("rst_stable",   32'(bus.stable),   32'h0);
        checkOutput("rst_peak",     32'(bus.peak_abs), 32'h0);
        checkOutput("rst_checksum", bus.checksum,      32'h0);

        applyStimulus(1'b0, 1'b1, 16'h1234);
        checkOutput("idle_valid_wr_count", 32'(bus.wr_count), 32'h0);
        checkOutput("idle_valid_overrun",  32'(bus.overrun),  32'h0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("t1_busy", 32'(bus.busy), 32'h1);
        for (int i = 1; i <= 10; i++) applyStimulus(1'b0, 1'b1, 16'(i * 100));
        checkOutput("t1_wr_count", 32'(bus.wr_count), 32'd10);
        checkOutput("t1_peak",     32'(bus.peak_abs), 32'h03E8);
        bus.rd_en = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0BAD);
        bus.rd_en = 1'b0;
        checkOutput("t1_rd_valid_capture", 32'(bus.rd_valid), 32'h0);
        checkOutput("t1_wr_count_11",      32'(bus.wr_count), 32'd11);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h5555);
        applyStimulus(1'b0, 1'b1, 16'h5555);
        rst = 1'b0;
        checkOutput("t1_rst_busy",     32'(bus.busy),     32'h0);
        checkOutput("t1_rst_done",     32'(bus.done),     32'h0);
        checkOutput("t1_rst_wr_count", 32'(bus.wr_count), 32'h0);
        checkOutput("t1_rst_peak",     32'(bus.peak_abs), 32'h0);
        checkOutput("t1_rst_checksum", bus.checksum,      32'h0);

        $display("[TB] full ramp run");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("t2_start_wr_count", 32'(bus.wr_count), 32'h0);
        for (int i = 0; i < 2048; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i));
            if (i == 2046) begin
                checkOutput("t2_pre_wr_count", 32'(bus.wr_count), 32'd2047);
                checkOutput("t2_pre_done",     32'(bus.done),     32'h0);
            end
        end
        checkOutput("t2_done",     32'(bus.done),     32'h1);
        checkOutput("t2_busy",     32'(bus.busy),     32'h0);
        checkOutput("t2_wr_count", 32'(bus.wr_count), 32'd2048);
        checkOutput("t2_peak",     32'(bus.peak_abs), 32'h07FF);
        checkOutput("t2_stable",   32'(bus.stable),   32'h1);
`ifdef IIR_CAP_CHECKSUM_EN
        exp_sum = 32'h001F_FC00;
`else
        exp_sum = 32'h0;
`endif
        checkOutput("t2_checksum", bus.checksum, exp_sum);
        readBack(11'd5);
        checkOutput("t2_rd5_data",  32'(bus.rd_data),  32'h0005);
        checkOutput("t2_rd5_valid", 32'(bus.rd_valid), 32'h1);
        readBack(11'd0);
        checkOutput("t2_rd0_data", 32'(bus.rd_data), 32'h0000);
        readBack(11'd2047);
        checkOutput("t2_rd2047_data", 32'(bus.rd_data), 32'h07FF);
        tick();
        checkOutput("t2_rd_valid_drop", 32'(bus.rd_valid), 32'h0);
        checkOutput("t2_rd_data_held",  32'(bus.rd_data),  32'h07FF);

        $display("[TB] overrun after done");
        applyStimulus(1'b0, 1'b1, 16'h1234);
        checkOutput("t5_overrun",  32'(bus.overrun),  32'h1);
        checkOutput("t5_done",     32'(bus.done),     32'h1);
        checkOutput("t5_wr_count", 32'(bus.wr_count), 32'd2048);
        readBack(11'd0);
        checkOutput("t5_buf_unchanged", 32'(bus.rd_data), 32'h0000);

        $display("[TB] sparse valids with one full-scale negative sample");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("t3_overrun_clr", 32'(bus.overrun),  32'h0);
        checkOutput("t3_done_clr",    32'(bus.done),     32'h0);
        checkOutput("t3_peak_clr",    32'(bus.peak_abs), 32'h0);
        checkOutput("t3_stable_clr",  32'(bus.stable),   32'h0);
        for (int k = 0; k < 2048; k++) begin
            applyStimulus(1'b0, 1'b1, (k == 10) ? Q15_MIN : 16'h0100);
            if (k == 1000) checkOutput("t3_wr_after_valid", 32'(bus.wr_count), 32'd1001);
            if (k == 2046) checkOutput("t3_pre_done", 32'(bus.done), 32'h0);
            if (k == 2047) begin
                checkOutput("t3_done",     32'(bus.done),     32'h1);
                checkOutput("t3_wr_count", 32'(bus.wr_count), 32'd2048);
            end
            applyStimulus(1'b0, 1'b0, 16'hDEAD);
            if (k == 1000) checkOutput("t3_wr_after_idle", 32'(bus.wr_count), 32'd1001);
        end
        checkOutput("t3_peak_sat", 32'(bus.peak_abs), 32'(Q15_MAX));
        checkOutput("t3_stable",   32'(bus.stable),   32'h1);
        checkOutput("t3_overrun",  32'(bus.overrun),  32'h0);
`ifdef IIR_CAP_CHECKSUM_EN
        exp_sum = 32'h0007_7F00;
`else
        exp_sum = 32'h0;
`endif
        checkOutput("t3_checksum", bus.checksum, exp_sum);
        readBack(11'd10);
        checkOutput("t3_rd10", 32'(bus.rd_data), 32'h8000);
        readBack(11'd11);
        checkOutput("t3_rd11", 32'(bus.rd_data), 32'h0100);

        $display("[TB] settling flag");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        for (int j = 0; j < 64; j++) applyStimulus(1'b0, 1'b1, 16'h1000);
        checkOutput("t4_stable_64", 32'(bus.stable),   32'h0);
        checkOutput("t4_peak",      32'(bus.peak_abs), 32'h1000);
        applyStimulus(1'b0, 1'b1, 16'h1000);
        checkOutput("t4_stable_65", 32'(bus.stable), 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h2000);
        checkOutput("t4_stable_drop", 32'(bus.stable),   32'h0);
        checkOutput("t4_wr_count",    32'(bus.wr_count), 32'd66);
        for (int j = 0; j < 34; j++) applyStimulus(1'b0, 1'b1, 16'h2000);
        checkOutput("t4_wr_count_100", 32'(bus.wr_count), 32'd100);

        $display("[TB] restart with coincident valid");
        applyStimulus(1'b1, 1'b1, 16'h7777);
        checkOutput("t6_wr_count", 32'(bus.wr_count), 32'h0);
        checkOutput("t6_peak",     32'(bus.peak_abs), 32'h0);
        checkOutput("t6_stable",   32'(bus.stable),   32'h0);
        checkOutput("t6_busy",     32'(bus.busy),     32'h1);
        checkOutput("t6_checksum", bus.checksum,      32'h0);
        for (int i = 0; i < 2048; i++) applyStimulus(1'b0, 1'b1, 16'hFFFF);
        checkOutput("t6_done",     32'(bus.done),     32'h1);
        checkOutput("t6_wr_count_full", 32'(bus.wr_count), 32'd2048);
        checkOutput("t6_peak_one", 32'(bus.peak_abs), 32'h0001);
        checkOutput("t6_stable_end", 32'(bus.stable), 32'h1);
`ifdef IIR_CAP_CHECKSUM_EN
        exp_sum = 32'hFFFF_F800;
`else
        exp_sum = 32'h0;
`endif
        checkOutput("t6_checksum_full", bus.checksum, exp_sum);
        readBack(11'd0);
        checkOutput("t6_rd0", 32'(bus.rd_data), 32'hFFFF);
        readBack(11'd2047);
        checkOutput("t6_rd2047", 32'(bus.rd_data), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
